// File: rtl/line_buffer_3x3.sv
// 3x3 sliding-window line buffer for a raster pixel stream feeding a pipelined 3x3 filter.
// Optional macro LINE_BUFFER_STRIDE2_EN flags only every other window in each direction (stride 2).
module line_buffer_3x3 #(
    parameter int WIDTH = 10,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 sof,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 win_valid,
    output logic [9*WIDTH-1:0]   win,
    output logic [9:0]           win_row,
    output logic [9:0]           win_col,
    output logic                 frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

    logic [9:0]       col_reg, col_next;
    logic [9:0]       row_reg, row_next;
    logic [9:0]       col_eff, row_eff;
    logic             last_col, last_row;
    logic             stride_ok;
    logic             win_valid_reg, win_valid_next;
    logic             frame_done_reg, frame_done_next;
    logic [9:0]       win_row_reg, win_col_reg;
    logic [AW-1:0]    rd_addr, wr_addr;

    logic [WIDTH-1:0] line1_mem [IMG_W];
    logic [WIDTH-1:0] line2_mem [IMG_W];
    logic [WIDTH-1:0] line1_rd_reg, line2_rd_reg;

    `ifdef LINE_BUFFER_STRIDE2_EN
    assign stride_ok = ~row_eff[0] & ~col_eff[0];
    `else
    assign stride_ok = 1'b1;
    `endif

    // sof relabels the incoming pixel as (0,0) before any position decision.
    always_comb begin
        col_eff         = sof ? 10'd0 : col_reg;
        row_eff         = sof ? 10'd0 : row_reg;
        last_col        = (col_eff == COL_LAST);
        last_row        = (row_eff == ROW_LAST);
        col_next        = col_reg;
        row_next        = row_reg;
        rd_addr         = col_reg[AW-1:0];
        wr_addr         = col_eff[AW-1:0];
        win_valid_next  = 1'b0;
        frame_done_next = 1'b0;
        if (in_valid) begin
            if (last_col) begin
                col_next = 10'd0;
                row_next = last_row ? 10'd0 : row_eff + 10'd1;
            end else begin
                col_next = col_eff + 10'd1;
                row_next = row_eff;
            end
            rd_addr         = col_next[AW-1:0];
            win_valid_next  = (row_eff >= 10'd2) && (col_eff >= 10'd2) && stride_ok;
            frame_done_next = !sof && last_row && last_col;
        end
    end

    // Line memories: the read is issued one pixel ahead (address of the next
    // expected column) so the registered read data is ready when that pixel arrives.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            line1_mem[wr_addr] <= in_data;
            line2_mem[wr_addr] <= line1_rd_reg;
        end
        line1_rd_reg <= line1_mem[rd_addr];
        line2_rd_reg <= line2_mem[rd_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            win_row_reg    <= '0;
            win_col_reg    <= '0;
        end else begin
            col_reg        <= col_next;
            row_reg        <= row_next;
            win_valid_reg  <= win_valid_next;
            frame_done_reg <= frame_done_next;
            if (win_valid_next) begin
                win_row_reg <= row_eff - 10'd1;
                win_col_reg <= col_eff - 10'd1;
            end
        end
    end

    // Window rows: row 0 from line2 (r-2), row 1 from line1 (r-1), row 2 live pixel.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_row
            logic [WIDTH-1:0] tap_reg [3];
            logic [WIDTH-1:0] tap_in;

            if (gi == 0) begin : gen_src_l2
                assign tap_in = line2_rd_reg;
            end else if (gi == 1) begin : gen_src_l1
                assign tap_in = line1_rd_reg;
            end else begin : gen_src_px
                assign tap_in = in_data;
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                    tap_reg[2] <= '0;
                end else if (in_valid) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= tap_in;
                end
            end

            for (gj = 0; gj < 3; gj++) begin : gen_tap
                assign win[(3*gi+gj)*WIDTH +: WIDTH] = tap_reg[gj];
            end
        end
    endgenerate

    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench for line_buffer_3x3: a picture-level model queues expected windows and frame ends.
module tb_line_buffer_3x3;
    localparam int WIDTH = 10;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 sof = 1'b0;
    logic                 in_valid = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 win_valid;
    logic [9*WIDTH-1:0]   win;
    logic [9:0]           win_row;
    logic [9:0]           win_col;
    logic                 frame_done;

    line_buffer_3x3 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .resetn(resetn), .sof(sof), .in_valid(in_valid), .in_data(in_data),
        .win_valid(win_valid), .win(win), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        logic [9*WIDTH-1:0] w;
        int                 r;
        int                 c;
    } exp_t;

    exp_t             win_q[$];
    int               fd_q[$];
    logic [WIDTH-1:0] img [IMG_H][IMG_W];
    int               m_row = 0;
    int               m_col = 0;
    int               errors = 0;
    int               checks = 0;
    int               win_pulses = 0;
    int               fd_pulses = 0;

`ifdef LINE_BUFFER_STRIDE2_EN
    localparam int EXP_WINS = ((IMG_H - 1) / 2) * ((IMG_W - 1) / 2);
`else
    localparam int EXP_WINS = (IMG_H - 2) * (IMG_W - 2);
`endif

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endfunction

    function automatic bit window_flagged(int r, int c);
`ifdef LINE_BUFFER_STRIDE2_EN
        return (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
        return (r >= 2) && (c >= 2);
`endif
    endfunction

    // Drive one pixel and record what the picture model says must come out.
    task automatic send(input logic s, input logic [WIDTH-1:0] d);
        int   r, c;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        sof      = s;
        in_data  = d;
        r = s ? 0 : m_row;
        c = s ? 0 : m_col;
        img[r][c] = d;
        if (window_flagged(r, c)) begin
            e.cyc = cyc + 1;
            e.r   = r - 1;
            e.c   = c - 1;
            e.w   = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[(3*i+j)*WIDTH +: WIDTH] = img[r-2+i][c-2+j];
            win_q.push_back(e);
        end
        if (!s && r == IMG_H - 1 && c == IMG_W - 1)
            fd_q.push_back(cyc + 1);
        c++;
        if (c == IMG_W) begin
            c = 0;
            r = (r == IMG_H - 1) ? 0 : r + 1;
        end
        m_row = r;
        m_col = c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            sof      = 1'b0;
        end
    endtask

    // mode 0: 4r+c dense, 1: 4r+c alternating gaps, 2: all -512
    task automatic frame(input int mode, input string tag);
        int wp, fp;
        wp = win_pulses;
        fp = fd_pulses;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                send(1'b0, (mode == 2) ? 10'h200 : WIDTH'(IMG_W * r + c));
                if (mode == 1) idle(1);
            end
        idle(3);
        chk({tag, "_win_count"}, 128'(win_pulses - wp), 128'(EXP_WINS));
        chk({tag, "_fd_count"}, 128'(fd_pulses - fp), 128'd1);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            while (win_q.size() > 0 && win_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL win_missing: got none expected window at cycle %0d", win_q[0].cyc);
                void'(win_q.pop_front());
            end
            while (fd_q.size() > 0 && fd_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL fd_missing: got none expected frame_done at cycle %0d", fd_q[0]);
                void'(fd_q.pop_front());
            end
            if (win_valid) begin
                win_pulses++;
                if (win_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL win_spurious: got win_valid at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = win_q.pop_front();
                    chk("win_cycle", 128'(cyc), 128'(e.cyc));
                    chk("win_data", 128'(win), 128'(e.w));
                    chk("win_row", 128'(win_row), 128'(e.r));
                    chk("win_col", 128'(win_col), 128'(e.c));
                end
            end
            if (frame_done) begin
                fd_pulses++;
                if (fd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fd_spurious: got frame_done at cycle %0d expected none", cyc);
                end else begin
                    chk("fd_cycle", 128'(cyc), 128'(fd_q.pop_front()));
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_win_valid"}, 128'(win_valid), 128'd0);
        chk({tag, "_frame_done"}, 128'(frame_done), 128'd0);
        chk({tag, "_win"}, 128'(win), 128'd0);
        chk({tag, "_win_row"}, 128'(win_row), 128'd0);
        chk({tag, "_win_col"}, 128'(win_col), 128'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;

        frame(0, "dense");
        frame(1, "gapped");
        frame(2, "neg512");

        // sof at pixel 6 of a frame, then a complete frame
        for (int k = 0; k < 6; k++) send(1'b0, WIDTH'(100 + k));
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                send((r == 0 && c == 0), WIDTH'(IMG_W * r + c));
        idle(3);
        chk("sof_q_empty", 128'(win_q.size()), 128'd0);

        // async reset after pixel 9, then a complete frame
        for (int k = 0; k < 10; k++) send(1'b0, WIDTH'(k));
        idle(2);
        chk("prereset_q_empty", 128'(win_q.size()), 128'd0);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_zero("midreset");
        m_row = 0;
        m_col = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        frame(0, "postreset");

        // sof on the last pixel of a frame suppresses frame_done
        for (int k = 0; k < IMG_W * IMG_H - 1; k++) send(1'b0, WIDTH'(k));
        send(1'b1, WIDTH'(7));
        idle(3);
        chk("sof_last_fd_q", 128'(fd_q.size()), 128'd0);

        // random pixels, random gaps, occasional sof
        for (int k = 0; k < 600; k++) begin
            send(($urandom_range(0, 49) == 0), WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);
        chk("final_win_q", 128'(win_q.size()), 128'd0);
        chk("final_fd_q", 128'(fd_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
